// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM state type and requester index helper shared by the UART TX arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  function automatic logic [2:0] next_idx(input logic [2:0] i, input int n);
    return (int'(i) == n - 1) ? 3'd0 : i + 3'd1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin encoder, first set request at or after ptr
module uart_tx_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   idx,
  output logic         any
);
  logic [N-1:0] rot;
  logic [3:0]   sum;
  assign rot = N'({req, req} >> ptr);
  assign any = |req;
  // Walk downward so the closest set bit to ptr is the last (winning) assignment
  always_comb begin
    idx = ptr;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'(k);
      if (rot[k]) idx = (sum >= 4'(N)) ? 3'(sum - 4'(N)) : sum[2:0];
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among byte requesters in bursts
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int ACK_TO    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic [2:0]         grant_id,
  output logic               arb_active,
  output logic               err_timeout
);
  state_t           state;
  logic [2:0]       rr_ptr, pick, nxt;
  logic             any, last_q, gv, glast, xfer;
  logic [3:0]       burst_cnt;
  logic [7:0]       timer, gbyte;
  logic [N_REQ-1:0] sel;
  uart_tx_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .idx(pick),
    .any(any)
  );
  assign sel        = N_REQ'(1) << grant_id;
  assign gv         = |(req_valid & sel);
  assign glast      = |(req_last & sel);
  assign gbyte      = 8'(req_data >> {grant_id, 3'b000});
  assign nxt        = next_idx(grant_id, N_REQ);
  assign req_ready  = (state == LOAD && !tx_busy) ? sel : '0;
  assign xfer       = |(req_valid & req_ready);
  assign arb_active = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      timer       <= '0;
      last_q      <= 1'b0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (any) begin
            grant_id <= pick;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (!gv) begin
            rr_ptr <= nxt;
            state  <= IDLE;
          end else if (xfer) begin
            tx_data   <= gbyte;
            last_q    <= glast;
            burst_cnt <= burst_cnt + 4'd1;
            tx_start  <= 1'b1;
            timer     <= '0;
            state     <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
          else begin
            timer <= timer + 8'd1;
            if (timer == 8'(ACK_TO - 1)) begin
              err_timeout <= 1'b1;
              rr_ptr      <= nxt;
              state       <= IDLE;
            end
          end
        end
        default: begin
          if (!tx_busy) begin
            if (last_q || burst_cnt == 4'(MAX_BURST) || !gv) begin
              rr_ptr <= nxt;
              state  <= IDLE;
            end else state <= LOAD;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-level reference model plus directed and random traffic
module tb_uart_tx_arbiter;
  localparam int N = 4, MB = 4, TO = 255;
  logic clk = 1'b0, rst_n = 1'b0, tx_busy = 1'b0;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic tx_start, arb_active, err_timeout;
  logic [2:0] grant_id;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .ACK_TO(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_active(arb_active), .err_timeout(err_timeout)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // Requester message queues: bit 8 marks the last byte of a message
  logic [8:0] mq [N][$];
  logic [N-1:0] en = '1;
  bit tx_hang = 0, man_busy = 0, busy_r = 0;
  int hold = 80;
  int grant_log[$], blen_log[$];
  logic [7:0] sent_log[$];
  int cyc = 0, first_ts_cyc = -1, vrise_cyc = -1, to_span = -1, ts_cyc = 0;
  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] last_sent = '0, e8;
  logic [N-1:0] prev_valid = '0, xf = '0;
  int m_ptr = 0, cur_g = 0, burst_n = 0, nb = 0, rise = 0, bleft = 0, e;
  bit burst_last = 0, exp_err = 0, prev_active = 0, rst_edge = 1, prev_xfer = 0, to_now, pv_g;
  function automatic int rr(input logic [N-1:0] v, input int p);
    logic [N-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = v >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return p;
  endfunction
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      xf = '0;
      if (rst_edge) begin
        chk("rst_ready", req_ready, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_active", arb_active, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_err", err_timeout, 0);
        exp_q.delete();
        last_sent = '0; m_ptr = 0; cur_g = 0; burst_n = 0; burst_last = 0; exp_err = 0; nb = 0;
      end else begin
        to_now = (nb == TO);
        if (to_now) exp_err = 1;
        chk("err_timeout", err_timeout, exp_err);
        if (arb_active && !prev_active) begin
          e = rr(prev_valid, m_ptr);
          chk("grant", grant_id, e);
          cur_g = e; burst_n = 0; burst_last = 0;
          grant_log.push_back(e);
        end else chk("grant_hold", grant_id, cur_g);
        pv_g = prev_valid[cur_g[1:0]];
        if (!arb_active && prev_active) begin
          chk("release_reason", to_now || burst_last || burst_n == MB || !pv_g, 1);
          blen_log.push_back(burst_n);
          m_ptr = (cur_g + 1) % N;
        end
        if (to_now) chk("timeout_idle", arb_active, 0);
        if (!prev_active && prev_valid != 0) chk("idle_grants", arb_active, 1);
        chk("ready_onehot", $countones(req_ready) <= 1, 1);
        if (!arb_active || tx_busy) chk("ready_zero", req_ready, 0);
        else chk("ready_sel", req_ready & ~(N'(1) << cur_g), 0);
        xf = req_valid & req_ready;
        for (int i = 0; i < N; i++) if (xf[i]) begin
          chk("burst_limit", !burst_last && burst_n < MB, 1);
          burst_n++;
          burst_last = mq[i][0][8];
          exp_q.push_back(mq[i][0][7:0]);
        end
        chk("tx_start_after_xfer", tx_start, prev_xfer);
        if (tx_start) begin
          e8 = exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx;
          chk("tx_data", tx_data, e8);
          last_sent = e8;
          sent_log.push_back(tx_data);
          ts_cyc = cyc;
          if (first_ts_cyc < 0) first_ts_cyc = cyc;
          if (!tx_hang) rise = 3;
        end else chk("tx_data_hold", tx_data, last_sent);
        if (err_timeout && to_span < 0) to_span = cyc - ts_cyc;
        nb = (tx_start && !tx_busy) ? 1 : (nb > 0 && nb < TO && !tx_busy) ? nb + 1 : 0;
      end
      if (req_valid != 0 && prev_valid == 0 && vrise_cyc < 0) vrise_cyc = cyc;
      prev_active = arb_active;
      prev_xfer = xf != 0;
      prev_valid = req_valid;
      @(posedge clk);
      #1;
      rst_edge = !rst_n;
      if (!rst_edge) for (int i = 0; i < N; i++) if (xf[i]) void'(mq[i].pop_front());
      if (rise > 0) begin
        rise--;
        if (rise == 0) begin
          busy_r = 1;
          bleft = (hold == 0) ? int'($urandom_range(12, 1)) : hold;
        end
      end else if (bleft > 0) begin
        bleft--;
        if (bleft == 0) busy_r = 0;
      end
      tx_busy = busy_r | man_busy;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = en[i] && mq[i].size() > 0;
        req_data[8*i +: 8] = mq[i].size() > 0 ? mq[i][0][7:0] : 8'h00;
        req_last[i] = mq[i].size() > 0 ? mq[i][0][8] : 1'b0;
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask
  task automatic clear_logs();
    grant_log.delete(); blen_log.delete(); sent_log.delete();
    first_ts_cyc = -1; vrise_cyc = -1; to_span = -1;
  endtask
  function automatic bit quiet();
    for (int i = 0; i < N; i++) if (mq[i].size() > 0) return 0;
    return !arb_active && !tx_busy;
  endfunction
  task automatic wait_quiet(input string nm);
    int n = 0;
    while (!quiet() && n < 20000) begin
      step(1);
      n++;
    end
    chk({"drain_", nm}, n < 20000, 1);
    step(2);
  endtask
  task automatic wait_for(input string nm, input bit busy_cond, input int lim);
    int n = 0;
    while (!(busy_cond ? tx_busy : arb_active) && n < lim) begin
      step(1);
      n++;
    end
    chk({"wait_", nm}, n < lim, 1);
  endtask
  int pushed, s0;
  initial begin
    do_reset();
    clear_logs();
    mq[0].push_back(9'h055);
    mq[0].push_back(9'h1A3);
    wait_quiet("single");
    chk("t1_count", sent_log.size(), 2);
    chk("t1_byte0", sent_log[0], 8'h55);
    chk("t1_byte1", sent_log[1], 8'hA3);
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_latency", first_ts_cyc - vrise_cyc, 2);
    mq[0].push_back(9'h111);
    mq[1].push_back(9'h122);
    wait_quiet("ptr1");
    chk("t1_ptr_first", grant_log[1], 1);
    chk("t1_ptr_second", grant_log[2], 0);
    do_reset();
    clear_logs();
    for (int i = 0; i < N; i++) for (int j = 0; j < 8; j++) mq[i].push_back(9'(16 * i + j));
    wait_quiet("contention");
    chk("t2_bursts", grant_log.size(), 8);
    for (int k = 0; k < 5; k++) begin
      chk("t2_order", grant_log[k], k % N);
      chk("t2_blen", blen_log[k], 4);
    end
    do_reset();
    mq[1].push_back(9'h101);
    wait_quiet("ptr2");
    clear_logs();
    mq[3].push_back(9'h133);
    mq[1].push_back(9'h111);
    wait_quiet("wrap");
    chk("t3_count", grant_log.size(), 2);
    chk("t3_first", grant_log[0], 3);
    chk("t3_second", grant_log[1], 1);
    do_reset();
    clear_logs();
    tx_hang = 1;
    mq[0].push_back(9'h1C0);
    mq[1].push_back(9'h1C1);
    wait_quiet("timeout");
    tx_hang = 0;
    chk("t4_err", err_timeout, 1);
    chk("t4_span", to_span, TO);
    chk("t4_grants", grant_log.size(), 2);
    chk("t4_next", grant_log[1], 1);
    do_reset();
    clear_logs();
    man_busy = 1;
    step(2);
    mq[2].push_back(9'h1E2);
    wait_for("grant2", 0, 20);
    step(2);
    en[2] = 1'b0;
    step(2);
    chk("t5_idle", arb_active, 0);
    chk("t5_no_start", sent_log.size(), 0);
    mq[2].delete();
    en[2] = 1'b1;
    man_busy = 0;
    wait_quiet("withdraw");
    do_reset();
    clear_logs();
    for (int j = 0; j < 4; j++) mq[0].push_back({j == 3, 8'hA0 + 8'(j)});
    wait_for("busy", 1, 200);
    do_reset();
    chk("t6_tx_start", tx_start, 0);
    chk("t6_ready", req_ready, 0);
    chk("t6_busy_held", tx_busy, 1);
    wait_quiet("reset_mid");
    chk("t6_count", sent_log.size(), 4);
    for (int j = 0; j < 4; j++) chk("t6_bytes", sent_log[j], 8'hA0 + 8'(j));
    do_reset();
    clear_logs();
    hold = 0;
    pushed = 0;
    for (int it = 0; it < 250; it++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(2, 0) == 0 && mq[i].size() < 4) begin
        s0 = $urandom_range(6, 1);
        for (int j = 0; j < s0; j++)
          mq[i].push_back({j == s0 - 1 && $urandom_range(3, 0) != 0, 8'($urandom)});
        pushed += s0;
      end
      step($urandom_range(30, 0));
    end
    wait_quiet("random");
    chk("rand_count", sent_log.size(), pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, limit 2000000 time units");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
